// File: rtl/controle_motores.sv
// controle_motores: arbitrates avancar/girar/remover into timed motor and brush drive.
// Optional ODOMETRIA_EN adds a saturating 16-bit count of cycles spent moving forward.
module controle_motores #(
  parameter int DEAD_TIME     = 4,
  parameter int TURN_CYCLES   = 8,
  parameter int REMOVE_CYCLES = 16
) (
  input  logic       clockc2,
  input  logic       reset,
  input  logic       avancar,
  input  logic       girar,
  input  logic       remover,
  output logic       motor_esq_en,
  output logic       motor_dir_en,
  output logic       motor_esq_fwd,
  output logic       motor_dir_fwd,
  output logic       escova,
  output logic       ocupado,
  output logic [7:0] giros_cnt
`ifdef ODOMETRIA_EN
  ,
  output logic [15:0] odometro
`endif
);

  localparam int MAXP_A = (DEAD_TIME > TURN_CYCLES) ? DEAD_TIME : TURN_CYCLES;
  localparam int MAXP   = (MAXP_A > REMOVE_CYCLES) ? MAXP_A : REMOVE_CYCLES;
  localparam int TW     = $clog2(MAXP) + 1;

  typedef logic [TW-1:0] tmr_t;

  typedef enum logic [2:0] {
    PARADO  = 3'd0,
    PAUSA   = 3'd1,
    FRENTE  = 3'd2,
    GIRO    = 3'd3,
    REMOCAO = 3'd4
  } state_t;

  localparam tmr_t T_DEAD = tmr_t'(DEAD_TIME - 1);
  localparam tmr_t T_TURN = tmr_t'(TURN_CYCLES - 1);
  localparam tmr_t T_REM  = tmr_t'(REMOVE_CYCLES - 1);

  state_t     state_q, state_d;
  tmr_t       tmr_q, tmr_d;
  logic [2:0] cmd_q;
  logic [7:0] giros_q, giros_d;
  logic [5:0] outs_q;

  // remover beats girar beats avancar
  function automatic state_t alvo(input logic [2:0] c);
    state_t s;
    case (1'b1)
      c[2]:    s = REMOCAO;
      c[1]:    s = GIRO;
      c[0]:    s = FRENTE;
      default: s = PARADO;
    endcase
    return s;
  endfunction

  function automatic tmr_t carga(input state_t s);
    tmr_t t;
    case (s)
      GIRO:    t = T_TURN;
      REMOCAO: t = T_REM;
      default: t = '0;
    endcase
    return t;
  endfunction

  // {esq_en, dir_en, esq_fwd, dir_fwd, escova, ocupado}
  function automatic logic [5:0] decod(input state_t s);
    logic [5:0] o;
    case (s)
      PAUSA:   o = 6'b000001;
      FRENTE:  o = 6'b111101;
      GIRO:    o = 6'b111001;
      REMOCAO: o = 6'b000011;
      default: o = 6'b000000;
    endcase
    return o;
  endfunction

  // next-state, timer and turn-count logic, driven only by the captured command
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    giros_d = giros_q;
    case (state_q)
      PARADO: begin
        state_d = alvo(cmd_q);
        tmr_d   = carga(state_d);
      end
      FRENTE: begin
        if (cmd_q != 3'b001) begin
          state_d = PAUSA;
          tmr_d   = T_DEAD;
        end
      end
      GIRO: begin
        if (cmd_q[2]) begin
          state_d = PAUSA;
          tmr_d   = T_DEAD;
        end else if (tmr_q == '0) begin
          giros_d = giros_q + 8'd1;
          state_d = PAUSA;
          tmr_d   = T_DEAD;
        end else begin
          tmr_d = tmr_q - tmr_t'(1);
        end
      end
      REMOCAO: begin
        if (tmr_q == '0) begin
          state_d = PAUSA;
          tmr_d   = T_DEAD;
        end else begin
          tmr_d = tmr_q - tmr_t'(1);
        end
      end
      PAUSA: begin
        if (tmr_q == '0) begin
          state_d = alvo(cmd_q);
          tmr_d   = carga(state_d);
        end else begin
          tmr_d = tmr_q - tmr_t'(1);
        end
      end
      default: begin
        state_d = PARADO;
        tmr_d   = '0;
      end
    endcase
  end

  // state, command capture and registered Moore outputs
  always_ff @(posedge clockc2 or negedge reset) begin
    if (!reset) begin
      state_q <= PARADO;
      tmr_q   <= '0;
      cmd_q   <= 3'b000;
      giros_q <= 8'd0;
      outs_q  <= 6'b000000;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cmd_q   <= {remover, girar, avancar};
      giros_q <= giros_d;
      outs_q  <= decod(state_d);
    end
  end

  assign motor_esq_en  = outs_q[5];
  assign motor_dir_en  = outs_q[4];
  assign motor_esq_fwd = outs_q[3];
  assign motor_dir_fwd = outs_q[2];
  assign escova        = outs_q[1];
  assign ocupado       = outs_q[0];
  assign giros_cnt     = giros_q;

`ifdef ODOMETRIA_EN
  logic [15:0] odo_q;

  // saturating count of cycles spent in FRENTE
  always_ff @(posedge clockc2 or negedge reset) begin
    if (!reset) begin
      odo_q <= 16'd0;
    end else if (state_q == FRENTE && odo_q != 16'hFFFF) begin
      odo_q <= odo_q + 16'd1;
    end
  end

  assign odometro = odo_q;
`endif

endmodule

// File: tb/tb_controle_motores.sv
// tb_controle_motores: random and directed stimulus against a mode/remaining-cycles model.
// Under ODOMETRIA_EN the forward odometer is also modelled and checked.
module tb_controle_motores;

  localparam int DEAD = 4;
  localparam int TURN = 8;
  localparam int REM  = 16;

  localparam int M_IDLE  = 0;
  localparam int M_GAP   = 1;
  localparam int M_FWD   = 2;
  localparam int M_TURN  = 3;
  localparam int M_BRUSH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic av = 1'b0, gi = 1'b0, re = 1'b0;
  logic esq_en, dir_en, esq_fwd, dir_fwd, esc, ocup;
  logic [7:0] giros;
`ifdef ODOMETRIA_EN
  logic [15:0] odo;
`endif

  int n_chk = 0;
  int n_err = 0;

  int m_mode = M_IDLE;
  int m_left = 0;
  logic [2:0] m_cmd = 3'b000;
  int m_turns = 0;
  int m_odo = 0;

  controle_motores dut (
    .clockc2(clk),
    .reset(rst_n),
    .avancar(av),
    .girar(gi),
    .remover(re),
    .motor_esq_en(esq_en),
    .motor_dir_en(dir_en),
    .motor_esq_fwd(esq_fwd),
    .motor_dir_fwd(dir_fwd),
    .escova(esc),
    .ocupado(ocup),
    .giros_cnt(giros)
`ifdef ODOMETRIA_EN
    ,
    .odometro(odo)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_out(input int mode);
    case (mode)
      M_GAP:   return 6'b000001;
      M_FWD:   return 6'b111101;
      M_TURN:  return 6'b111001;
      M_BRUSH: return 6'b000011;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic int wanted(input logic [2:0] c);
    if (c[2]) return M_BRUSH;
    if (c[1]) return M_TURN;
    if (c[0]) return M_FWD;
    return M_IDLE;
  endfunction

  task automatic enter(input int mode);
    m_mode = mode;
    if (mode == M_TURN) m_left = TURN;
    else if (mode == M_BRUSH) m_left = REM;
    else if (mode == M_GAP) m_left = DEAD;
    else m_left = 0;
  endtask

  task automatic model_step();
    if (m_mode == M_FWD && m_odo < 65535) m_odo++;
    case (m_mode)
      M_IDLE: enter(wanted(m_cmd));
      M_FWD: if (m_cmd != 3'b001) enter(M_GAP);
      M_TURN: begin
        if (m_cmd[2]) enter(M_GAP);
        else begin
          m_left--;
          if (m_left == 0) begin
            m_turns++;
            enter(M_GAP);
          end
        end
      end
      M_BRUSH: begin
        m_left--;
        if (m_left == 0) enter(M_GAP);
      end
      M_GAP: begin
        m_left--;
        if (m_left == 0) enter(wanted(m_cmd));
      end
      default: enter(M_IDLE);
    endcase
    m_cmd = {re, gi, av};
  endtask

  task automatic compare();
    chk("saidas", {26'd0, esq_en, dir_en, esq_fwd, dir_fwd, esc, ocup},
        {26'd0, exp_out(m_mode)});
    chk("giros", {24'd0, giros}, 32'(m_turns % 256));
`ifdef ODOMETRIA_EN
    chk("odometro", {16'd0, odo}, 32'(m_odo));
`endif
  endtask

  task automatic run(input logic [2:0] c, input int n);
    {re, gi, av} = c;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    {re, gi, av} = 3'b000;
    #1;
    chk("rst_async", {26'd0, esq_en, dir_en, esq_fwd, dir_fwd, esc, ocup}, 32'd0);
    m_mode = M_IDLE;
    m_left = 0;
    m_cmd = 3'b000;
    m_turns = 0;
    m_odo = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_giros", {24'd0, giros}, 32'd0);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int c;
    do_reset();
    run(3'b000, 3);
    // reset asserted in the middle of forward motion
    run(3'b001, 6);
    do_reset();
    run(3'b000, 4);
    // forward then stop
    run(3'b001, 5);
    run(3'b000, 8);
    // turn requested while moving forward
    run(3'b001, 3);
    run(3'b011, 14);
    run(3'b001, 10);
    run(3'b000, 8);
    // turn aborted by a one-cycle remover pulse
    run(3'b010, 3);
    run(3'b110, 1);
    run(3'b000, 30);
    // all requests together, then girar alone
    run(3'b111, 3);
    run(3'b010, 40);
    run(3'b000, 20);
    // random segments
    for (int s = 0; s < 300; s++) begin
      logic [2:0] r;
      r[0] = ($urandom_range(0, 2) != 0);
      r[1] = ($urandom_range(0, 3) == 0);
      r[2] = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 30) == 0) do_reset();
      run(r, $urandom_range(1, 20));
    end
    // 256 completed turns wrap the counter
    do_reset();
    c = 0;
    while (m_turns < 256 && c < 5000) begin
      run(3'b010, 1);
      c++;
    end
    chk("wrap_bound", 32'(c < 5000), 32'd1);
    chk("giros_wrap", {24'd0, giros}, 32'd0);
    run(3'b000, 10);
`ifdef ODOMETRIA_EN
    do_reset();
    run(3'b001, 70001);
    chk("odo_sat", {16'd0, odo}, 32'hFFFF);
    run(3'b000, 6);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
